// File: rtl/hps_led_fader_if.sv
// Bus between the HPS LED PIO out_port side and the LED fader.
interface hps_led_fader_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] led_in;
    logic             enable;
    logic [WIDTH-1:0] led_out;
    logic             busy;
    logic             pwm_wrap;

    modport master (
        output led_in, enable,
        input  led_out, busy, pwm_wrap
    );

    modport slave (
        input  led_in, enable,
        output led_out, busy, pwm_wrap
    );
endinterface

// File: rtl/hps_led_fader.sv
// PWM fader for the HPS LED PIO: each LED ramps toward its on/off target.
// Define LED_FADE_GAMMA_EN for squared (perceptual) duty instead of linear.
module hps_led_fader_lane #(
    parameter int PWM_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_led,
    input  logic                i_enable,
    input  logic                i_step,
    input  logic [PWM_BITS-1:0] i_cnt,
    output logic                o_led,
    output logic                o_mismatch
);
    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic [PWM_BITS-1:0] r_lvl;
    logic                r_led;
    logic [PWM_BITS-1:0] w_tgt;
    logic [PWM_BITS-1:0] w_duty;

    assign w_tgt = {PWM_BITS{i_led}};

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] w_sq;
    assign w_sq   = {{PWM_BITS{1'b0}}, r_lvl} * {{PWM_BITS{1'b0}}, r_lvl};
    assign w_duty = w_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign w_duty = r_lvl;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lvl <= '0;
            r_led <= 1'b0;
        end else if (!i_enable) begin
            // Pass-through drives the pin straight from led_in so the pin lags
            // the input by one cycle; the level tracks it for a clean re-enable.
            r_lvl <= w_tgt;
            r_led <= i_led;
        end else begin
            if (i_step) begin
                if (r_lvl < w_tgt)
                    r_lvl <= r_lvl + 1'b1;
                else if (r_lvl > w_tgt)
                    r_lvl <= r_lvl - 1'b1;
            end
            r_led <= (r_lvl == MAX) || (w_duty > i_cnt);
        end
    end

    assign o_led      = r_led;
    assign o_mismatch = (r_lvl != w_tgt);
endmodule

module hps_led_fader #(
    parameter int WIDTH    = 10,
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 1024
) (
    input  logic            i_clk,
    input  logic            i_reset,
    hps_led_fader_if.slave  io_bus
);
    localparam int                  PRE_W    = $clog2(STEP_DIV);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;

    logic [PWM_BITS-1:0] r_cnt;
    logic [PRE_W-1:0]    r_pre;
    logic                r_busy;
    logic                r_wrap;
    logic                w_step;
    logic [WIDTH-1:0]    w_led;
    logic [WIDTH-1:0]    w_mismatch;

    assign w_step = (r_pre == PRE_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_pre  <= '0;
            r_busy <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_pre  <= w_step ? '0 : r_pre + 1'b1;
            r_wrap <= (r_cnt == CNT_MAX);
            r_busy <= io_bus.enable && (|w_mismatch);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        hps_led_fader_lane #(.PWM_BITS(PWM_BITS)) u_lane (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_led      (io_bus.led_in[i]),
            .i_enable   (io_bus.enable),
            .i_step     (w_step),
            .i_cnt      (r_cnt),
            .o_led      (w_led[i]),
            .o_mismatch (w_mismatch[i])
        );
    end

    assign io_bus.led_out  = w_led;
    assign io_bus.busy     = r_busy;
    assign io_bus.pwm_wrap = r_wrap;
endmodule
